// File: rtl/parallel_serial_pkg.sv
// Shared serial-link constants: link width, COM/idle symbol and transmitter FSM encodings.
package parallel_serial_pkg;
    localparam int         LINK_WIDTH = 8;
    localparam logic [7:0] COM_SYM    = 8'hBC;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
endpackage

// File: rtl/parallel_serial_shreg.sv
// WIDTH-bit parallel-load, left-shift register; its MSB is the serial output.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);
    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            shreg_q <= '0;
        else if (load_i)
            shreg_q <= data_i;
        else if (shift_i)
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
    end

    assign msb_o = shreg_q[WIDTH-1];
endmodule

// File: rtl/parallel_serial.sv
// Serial-link transmitter: idle preamble after reset, then one byte (or idle) per WIDTH-bit slot, MSB first.
module parallel_serial
    import parallel_serial_pkg::*;
#(
    parameter int               WIDTH       = LINK_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_SYM    = WIDTH'(COM_SYM),
    parameter int               ALIGN_COUNT = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic             DATA_OUT,
    output logic             SENDING
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = $clog2(ALIGN_COUNT + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [SW-1:0] LAST_SYM = SW'(ALIGN_COUNT - 1);

    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]    sym_cnt_q, sym_cnt_d;
    logic             sending_q, sending_d;
    logic             load, shift, run_bnd, boundary;
    logic [WIDTH-1:0] load_val;

    assign boundary = (bit_cnt_q == LAST_BIT);

    // The last preamble boundary already hands off to RUN, so data can land right after the preamble.
    assign READY_OUT = boundary &&
                       (state_q == ST_RUN || (state_q == ST_ALIGN && sym_cnt_q == LAST_SYM));
    assign SENDING   = sending_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sym_cnt_d = sym_cnt_q;
        sending_d = sending_q;
        load      = 1'b0;
        shift     = 1'b0;
        run_bnd   = 1'b0;
        load_val  = IDLE_SYM;
        if (state_q == ST_LOAD) begin
            load      = 1'b1;
            bit_cnt_d = '0;
            sym_cnt_d = '0;
            state_d   = ST_ALIGN;
        end else if (!boundary) begin
            shift     = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
            bit_cnt_d = '0;
            load      = 1'b1;
            if (state_q == ST_ALIGN) begin
                sym_cnt_d = sym_cnt_q + 1'b1;
                if (sym_cnt_q == LAST_SYM) begin
                    state_d = ST_RUN;
                    run_bnd = 1'b1;
                end
            end else begin
                run_bnd = 1'b1;
            end
            if (run_bnd) begin
                sending_d = VALID_IN;
                if (VALID_IN)
                    load_val = DATA_IN;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_LOAD;
            bit_cnt_q <= '0;
            sym_cnt_q <= '0;
            sending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sym_cnt_q <= sym_cnt_d;
            sending_q <= sending_d;
        end
    end

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (load_val),
        .msb_o   (DATA_OUT)
    );
endmodule
